// File: rtl/ternary_neuron_acc_if.sv
// Beat / result handshake bundle for the ternary neuron accumulator.
// The master side drives beats and consumes results; the slave side is the
// accumulator itself.
interface ternary_neuron_acc_if #(
  parameter int PC_W  = 5,
  parameter int ACC_W = 10
) ();

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [PC_W-1:0]   pc_pos;
  logic [PC_W-1:0]   pc_neg;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_act;
  logic [ACC_W-1:0]  out_sum;
  logic              out_sat;

  modport master (
    output in_valid, in_last, pc_pos, pc_neg, out_ready,
    input  in_ready, out_valid, out_act, out_sum, out_sat
  );

  modport slave (
    input  in_valid, in_last, pc_pos, pc_neg, out_ready,
    output in_ready, out_valid, out_act, out_sum, out_sat
  );

endinterface

// File: rtl/ternary_neuron_acc.sv
// Accumulate-and-activate stage: sums (pc_pos - pc_neg) over a frame with
// saturation, then thresholds the frame sum into a ternary activation
// (01 = +1, 11 = -1, 00 = 0). The result is held until downstream accepts it;
// a new frame's first beat may be taken in the same cycle the result leaves.
module ternary_neuron_acc #(
  parameter int PC_W   = 5,
  parameter int ACC_W  = 10,
  parameter int THR_HI = 2,
  parameter int THR_LO = -3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ternary_neuron_acc_if.slave  bus
);

  // Two guard bits cover base + diff without overflow before clamping.
  localparam int SUM_W = ACC_W + 2;

  localparam logic signed [SUM_W-1:0] SUM_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0]        ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]        ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] THR_HI_C = ACC_W'(THR_HI);
  localparam logic signed [ACC_W-1:0] THR_LO_C = ACC_W'(THR_LO);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               first_q, first_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         out_act_q, out_act_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_sat_q, out_sat_d;

  logic               in_ready_s;
  logic               accept_s;
  logic signed [SUM_W-1:0] diff_s;
  logic signed [SUM_W-1:0] base_s;
  logic signed [SUM_W-1:0] sum_s;
  logic [ACC_W-1:0]   nxt_s;
  logic               clamped_s;
  logic               sat_new_s;

  // Ternary activation of a signed frame sum; sums equal to a threshold map to 0.
  function automatic logic [1:0] act_of(input logic [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] v;
    v = $signed(sum);
    if (v > THR_HI_C) begin
      return 2'b01;
    end else if (v < THR_LO_C) begin
      return 2'b11;
    end else begin
      return 2'b00;
    end
  endfunction

  // Handshake: always ready while accumulating, ready with downstream while holding.
  always_comb begin
    in_ready_s = 1'b1;
    if (state_q == ST_HOLD) begin
      in_ready_s = bus.out_ready;
    end else begin
      in_ready_s = 1'b1;
    end
    accept_s = bus.in_valid & in_ready_s;
  end

  // Datapath: signed difference added to the running sum, clamped to ACC_W bits.
  always_comb begin
    diff_s    = $signed({{(SUM_W-PC_W){1'b0}}, bus.pc_pos})
              - $signed({{(SUM_W-PC_W){1'b0}}, bus.pc_neg});
    base_s    = first_q ? '0 : {{2{acc_q[ACC_W-1]}}, acc_q};
    sum_s     = base_s + diff_s;
    nxt_s     = sum_s[ACC_W-1:0];
    clamped_s = 1'b0;
    if (sum_s > SUM_MAX) begin
      nxt_s     = ACC_MAX;
      clamped_s = 1'b1;
    end else if (sum_s < SUM_MIN) begin
      nxt_s     = ACC_MIN;
      clamped_s = 1'b1;
    end else begin
      nxt_s     = sum_s[ACC_W-1:0];
      clamped_s = 1'b0;
    end
    sat_new_s = (first_q ? 1'b0 : sat_q) | clamped_s;
  end

  // Next-state and result logic for the ACC/HOLD controller.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    first_d     = first_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_act_d   = out_act_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;

    if (accept_s) begin
      acc_d   = nxt_s;
      sat_d   = sat_new_s;
      first_d = bus.in_last;
    end else begin
      acc_d   = acc_q;
    end

    case (state_q)
      ST_ACC: begin
        if (accept_s && bus.in_last) begin
          out_valid_d = 1'b1;
          out_sum_d   = nxt_s;
          out_sat_d   = sat_new_s;
          out_act_d   = act_of(nxt_s);
          state_d     = ST_HOLD;
        end else begin
          state_d     = ST_ACC;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          if (accept_s && bus.in_last) begin
            // Result consumed and a single-beat frame completes in the same cycle.
            out_valid_d = 1'b1;
            out_sum_d   = nxt_s;
            out_sat_d   = sat_new_s;
            out_act_d   = act_of(nxt_s);
            state_d     = ST_HOLD;
          end else begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_ACC;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      first_q     <= 1'b1;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_act_q   <= 2'b00;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_act   = out_act_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Bench for ternary_neuron_acc: two instances (ACC_W=10 and ACC_W=6), a
// frame-level reference model checked every negedge, plus literal checks.
module tb_ternary_neuron_acc;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  ternary_neuron_acc_if #(.PC_W(5), .ACC_W(10)) b0 ();
  ternary_neuron_acc_if #(.PC_W(5), .ACC_W(6))  b1 ();

  ternary_neuron_acc #(.PC_W(5), .ACC_W(10), .THR_HI(2), .THR_LO(-3)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  ternary_neuron_acc #(.PC_W(5), .ACC_W(6), .THR_HI(2), .THR_LO(-3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  always #5 clk = ~clk;

  // Reference model state, one slot per instance.
  int aw [2] = '{10, 6};
  int m_sum [2];
  bit m_first [2];
  bit m_sat [2];
  bit m_hold [2];
  bit m_valid [2];
  int m_osum [2];
  bit m_osat [2];
  int m_oact [2];

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int act_code(input int s);
    if (s > 2) return 1;
    if (s < -3) return 3;
    return 0;
  endfunction

  task automatic model_step(input int k, input logic rstn, input logic iv, input logic il,
                            input int pp, input int pn, input logic ordy, input logic irdy,
                            input logic ov, input int dact, input int dsum, input logic dsat);
    int hi, lo, base, s;
    bit cl, acc_ok;
    hi = (1 << (aw[k] - 1)) - 1;
    lo = -(1 << (aw[k] - 1));
    if (!rstn) begin
      chk($sformatf("dut%0d reset out_valid", k), int'(ov), 0);
      chk($sformatf("dut%0d reset out_sum", k), dsum, 0);
      chk($sformatf("dut%0d reset out_act", k), dact, 0);
      chk($sformatf("dut%0d reset out_sat", k), int'(dsat), 0);
      m_sum[k] = 0; m_first[k] = 1'b1; m_sat[k] = 1'b0;
      m_hold[k] = 1'b0; m_valid[k] = 1'b0;
    end else begin
      chk($sformatf("dut%0d in_ready", k), int'(irdy), int'(!m_hold[k] || ordy));
      chk($sformatf("dut%0d out_valid", k), int'(ov), int'(m_valid[k]));
      if (m_valid[k]) begin
        chk($sformatf("dut%0d out_sum", k), dsum, m_osum[k]);
        chk($sformatf("dut%0d out_act", k), dact, m_oact[k]);
        chk($sformatf("dut%0d out_sat", k), int'(dsat), int'(m_osat[k]));
      end
      acc_ok = iv && (!m_hold[k] || ordy);
      if (m_hold[k] && ordy) begin
        m_hold[k] = 1'b0;
        m_valid[k] = 1'b0;
      end
      if (acc_ok) begin
        base = m_first[k] ? 0 : m_sum[k];
        s = base + pp - pn;
        cl = 1'b0;
        if (s > hi) begin s = hi; cl = 1'b1; end
        else if (s < lo) begin s = lo; cl = 1'b1; end
        m_sat[k] = (m_first[k] ? 1'b0 : m_sat[k]) | cl;
        m_sum[k] = s;
        m_first[k] = il;
        if (il) begin
          m_valid[k] = 1'b1;
          m_hold[k] = 1'b1;
          m_osum[k] = s;
          m_osat[k] = m_sat[k];
          m_oact[k] = act_code(s);
        end
      end
    end
  endtask

  // Compare process: every negedge, check both DUTs against the model and advance it.
  initial begin
    forever begin
      @(negedge clk);
      model_step(0, rst_n, b0.in_valid, b0.in_last, int'(b0.pc_pos), int'(b0.pc_neg),
                 b0.out_ready, b0.in_ready, b0.out_valid, int'(b0.out_act),
                 int'($signed(b0.out_sum)), b0.out_sat);
      model_step(1, rst_n, b1.in_valid, b1.in_last, int'(b1.pc_pos), int'(b1.pc_neg),
                 b1.out_ready, b1.in_ready, b1.out_valid, int'(b1.out_act),
                 int'($signed(b1.out_sum)), b1.out_sat);
    end
  end

  task automatic drive(input int k, input logic iv, input int p, input int n, input logic l);
    if (k == 0) begin
      b0.in_valid = iv; b0.pc_pos = 5'(p); b0.pc_neg = 5'(n); b0.in_last = l;
    end else begin
      b1.in_valid = iv; b1.pc_pos = 5'(p); b1.pc_neg = 5'(n); b1.in_last = l;
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? b0.in_ready : b1.in_ready;
  endfunction

  // One beat: drive after a posedge, wait (bounded) for in_ready, release after the accept edge.
  task automatic send(input int k, input int p, input int n, input logic l);
    bit ok;
    @(posedge clk); #1;
    drive(k, 1'b1, p, n, l);
    ok = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rdy(k)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("dut%0d beat handshake", k), 0, 1);
    @(posedge clk); #1;
    drive(k, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic expect_out(input int k, input int sum, input int act, input int sat);
    @(negedge clk);
    if (k == 0) begin
      chk("lit dut0 out_valid", int'(b0.out_valid), 1);
      chk("lit dut0 out_sum", int'($signed(b0.out_sum)), sum);
      chk("lit dut0 out_act", int'(b0.out_act), act);
      chk("lit dut0 out_sat", int'(b0.out_sat), sat);
    end else begin
      chk("lit dut1 out_valid", int'(b1.out_valid), 1);
      chk("lit dut1 out_sum", int'($signed(b1.out_sum)), sum);
      chk("lit dut1 out_act", int'(b1.out_act), act);
      chk("lit dut1 out_sat", int'(b1.out_sat), sat);
    end
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit idle out_valid", int'(b0.out_valid), 0);
    chk("lit idle in_ready", int'(b0.in_ready), 1);

    // Single-beat frame.
    send(0, 10, 3, 1'b1);
    expect_out(0, 7, 1, 0);

    // Three beats with gaps: -4, -6, -7.
    send(0, 5, 9, 1'b0);
    send(0, 2, 4, 1'b0);
    send(0, 0, 1, 1'b1);
    expect_out(0, -7, 3, 0);

    // Threshold boundaries.
    send(0, 2, 0, 1'b1); expect_out(0, 2, 0, 0);
    send(0, 3, 0, 1'b1); expect_out(0, 3, 1, 0);
    send(0, 0, 3, 1'b1); expect_out(0, -3, 0, 0);
    send(0, 0, 4, 1'b1); expect_out(0, -4, 3, 0);

    // Backpressure: result held, next beat stalled, then accepted on consume.
    @(posedge clk); #1 b0.out_ready = 1'b0;
    send(0, 5, 0, 1'b1);
    drive(0, 1'b1, 4, 0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("lit bp in_ready", int'(b0.in_ready), 0);
      chk("lit bp out_valid", int'(b0.out_valid), 1);
      chk("lit bp out_sum", int'($signed(b0.out_sum)), 5);
      chk("lit bp out_act", int'(b0.out_act), 1);
    end
    @(posedge clk); #1 b0.out_ready = 1'b1;
    @(negedge clk);
    chk("lit bp release in_ready", int'(b0.in_ready), 1);
    @(posedge clk); #1 drive(0, 1'b0, 0, 0, 1'b0);
    expect_out(0, 4, 1, 0);

    // Reset mid-frame discards the partial sum.
    send(0, 20, 0, 1'b0);
    send(0, 20, 0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("lit rst out_valid", int'(b0.out_valid), 0);
    chk("lit rst out_sum", int'($signed(b0.out_sum)), 0);
    chk("lit rst out_act", int'(b0.out_act), 0);
    chk("lit rst out_sat", int'(b0.out_sat), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(0, 1, 2, 1'b1);
    expect_out(0, -1, 0, 0);

    // Narrow accumulator: positive and negative saturation, sticky-per-frame sat.
    send(1, 31, 0, 1'b0);
    send(1, 31, 0, 1'b1);
    expect_out(1, 31, 1, 1);
    send(1, 1, 0, 1'b1);
    expect_out(1, 1, 0, 0);
    send(1, 0, 31, 1'b0);
    send(1, 0, 31, 1'b1);
    expect_out(1, -32, 3, 1);
    send(1, 0, 31, 1'b1);
    expect_out(1, -31, 3, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
